// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock.
// Optional macro AES_INV_SBOX_PIPE_EN registers the S-box outputs and adds a PIPE drain state.
module aes_inv_sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int unsigned NumGroups = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned GrpW      = 8 * BYTES_PER_CYCLE;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

    // Entry 0x00 sits in the top byte, so entry b lives at bit offset 8*(255-b).
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[{~b, 3'b000} +: 8];
    endfunction

`ifdef AES_INV_SBOX_PIPE_EN
    typedef enum logic [1:0] {StIdle, StProc, StPipe, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StProc, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [127:0]     data_q, data_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [127:0]     lk_vec;
    logic [GrpW-1:0]  lk_grp, lk_sub;
    logic [GrpW-1:0]  wb_grp;
    logic [CntW-1:0]  wb_cnt;
    logic             wb_en;
    logic [127:0]     wb_top, mask_top, wb_vec, wb_mask;

    // Bring the current group to the top of the word so the S-box slice is fixed.
    assign lk_vec = data_q << (GrpW * 32'(cnt_q));
    assign lk_grp = lk_vec[127 -: GrpW];

    for (genvar j = 0; j < int'(BYTES_PER_CYCLE); j++) begin : g_sbox
        assign lk_sub[GrpW-1-8*j -: 8] = inv_sbox(lk_grp[GrpW-1-8*j -: 8]);
    end

`ifdef AES_INV_SBOX_PIPE_EN
    logic [GrpW-1:0] sbox_q;
    logic [CntW-1:0] wb_cnt_q;
    logic            wb_valid_q;

    // Lookup of group k overlaps the writeback of group k-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_q     <= '0;
            wb_cnt_q   <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= (state_q == StProc);
            if (state_q == StProc) begin
                sbox_q   <= lk_sub;
                wb_cnt_q <= cnt_q;
            end
        end
    end

    assign wb_grp = sbox_q;
    assign wb_cnt = wb_cnt_q;
    assign wb_en  = wb_valid_q;
    assign busy   = (state_q == StProc) || (state_q == StPipe);
`else
    assign wb_grp = lk_sub;
    assign wb_cnt = cnt_q;
    assign wb_en  = (state_q == StProc);
    assign busy   = (state_q == StProc);
`endif

    always_comb begin
        wb_top                = '0;
        wb_top[127 -: GrpW]   = wb_grp;
        mask_top              = '0;
        mask_top[127 -: GrpW] = '1;
    end

    assign wb_vec  = wb_top >> (GrpW * 32'(wb_cnt));
    assign wb_mask = mask_top >> (GrpW * 32'(wb_cnt));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        if (wb_en) begin
            data_d = (data_q & ~wb_mask) | wb_vec;
        end
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StProc: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
`ifdef AES_INV_SBOX_PIPE_EN
                    state_d = StPipe;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef AES_INV_SBOX_PIPE_EN
            StPipe: state_d = StDone;
`endif
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Accept overrides the DONE->IDLE release so back-to-back jobs have no bubble.
        if (in_valid && in_ready) begin
            data_d  = state_in;
            cnt_d   = '0;
            state_d = StProc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign state_out = data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Scoreboard bench for aes_inv_sub_bytes_seq: main instance at 4 bytes/cycle plus 1 and 16
// bytes/cycle instances for the sweep. Honours AES_INV_SBOX_PIPE_EN for latency expectations.
module tb_aes_inv_sub_bytes_seq;

`ifdef AES_INV_SBOX_PIPE_EN
    localparam int PipeLat = 1;
`else
    localparam int PipeLat = 0;
`endif
    localparam int Lat   = 4 + PipeLat;
    localparam int Lat1  = 16 + PipeLat;
    localparam int Lat16 = 1 + PipeLat;

    localparam logic [127:0] V63   = {16{8'h63}};
    localparam logic [127:0] E63   = 128'h0;
    localparam logic [127:0] VInc  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] EInc  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VZero = 128'h0;
    localparam logic [127:0] EZero = {16{8'h52}};
    localparam logic [127:0] V16   = {16{8'h16}};
    localparam logic [127:0] E16   = {16{8'hff}};
    localparam logic [127:0] VMix  = {4{32'h16007c63}};
    localparam logic [127:0] EMix  = {4{32'hff520100}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] state_in, state_out;

    logic         sw_valid, sw_ready_tie;
    logic [127:0] sw_state;
    logic         s1_in_ready, s1_valid, s1_busy;
    logic [127:0] s1_out;
    logic         s16_in_ready, s16_valid, s16_busy;
    logic [127:0] s16_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sw_acc = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [127:0] sq1[$];
    logic [127:0] sq16[$];

    always #5 clk = ~clk;

    aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );

    aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_in_ready),
        .state_in(sw_state), .out_valid(s1_valid), .out_ready(sw_ready_tie),
        .state_out(s1_out), .busy(s1_busy)
    );

    aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_bpc16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s16_in_ready),
        .state_in(sw_state), .out_valid(s16_valid), .out_ready(sw_ready_tie),
        .state_out(s16_out), .busy(s16_busy)
    );

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Main-instance monitor: pops the scoreboard on every output handshake.
    initial begin
        logic         prev_valid;
        logic         prev_hs;
        logic [127:0] prev_out;
        logic [127:0] e;
        int           a;
        int           rise_cyc;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_out   = '0;
        rise_cyc   = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                if (out_valid && (!prev_valid || prev_hs)) rise_cyc = cyc;
                if (out_valid && prev_valid && !prev_hs) begin
                    check128("hold_data", state_out, prev_out);
                    check128("hold_in_ready", {127'b0, in_ready}, {127'b0, out_ready});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h want none", state_out);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check128("result", state_out, e);
                        check_int("latency", rise_cyc - a, Lat);
                    end
                end
                prev_valid = out_valid;
                prev_hs    = out_valid && out_ready;
                prev_out   = state_out;
            end
        end
    end

    // Sweep monitor: out_ready is tied high, so each valid cycle is one handshake.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && s1_valid) begin
            if (sq1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bpc1_unexpected: got %h want none", s1_out);
            end else begin
                check128("bpc1_result", s1_out, sq1.pop_front());
                check_int("bpc1_latency", cyc - sw_acc, Lat1);
            end
        end
        if (rst_n && s16_valid) begin
            if (sq16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bpc16_unexpected: got %h want none", s16_out);
            end else begin
                check128("bpc16_result", s16_out, sq16.pop_front());
                check_int("bpc16_latency", cyc - sw_acc, Lat16);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [127:0] d, input logic [127:0] e, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        state_in = d;
        #1;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sq1.size() != 0 || sq16.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0 || sq1.size() != 0 || sq16.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0",
                     exp_q.size() + sq1.size() + sq16.size());
        end
    endtask

    task automatic sw_send(input logic [127:0] d, input logic [127:0] e);
        sw_valid = 1'b1;
        sw_state = d;
        #1;
        check128("sweep_ready", {126'b0, s1_in_ready, s16_in_ready}, 128'd3);
        @(posedge clk);
        #1;
        sw_acc = cyc;
        sq1.push_back(e);
        sq16.push_back(e);
        @(negedge clk);
        sw_valid = 1'b0;
    endtask

    initial begin
        int w;
        int n;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        state_in     = '0;
        out_ready    = 1'b1;
        sw_valid     = 1'b0;
        sw_state     = '0;
        sw_ready_tie = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check128("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check128("reset_in_ready", {127'b0, in_ready}, 128'd1);
        check128("reset_busy", {127'b0, busy}, 128'd0);
        check128("reset_state_out", state_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back-to-back with out_ready held high.
        send(V63, E63, w);
        send(VInc, EInc, w);
        send(VZero, EZero, w);
        send(V16, E16, w);
        send(VMix, EMix, w);
        drain();

        // Backpressure, then simultaneous output release and new accept.
        out_ready = 1'b0;
        send(VInc, EInc, w);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (10) @(negedge clk);
        #1;
        check128("stall_in_ready", {127'b0, in_ready}, 128'd0);
        check128("stall_out_valid", {127'b0, out_valid}, 128'd1);
        out_ready = 1'b1;
        send(VZero, EZero, w);
        check_int("no_bubble_waits", w, 0);
        check128("no_bubble_busy", {126'b0, busy, out_valid}, 128'd2);
        drain();

        // Reset in the middle of a job.
        send(VInc, EInc, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        check128("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        check128("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        check128("midrst_busy", {127'b0, busy}, 128'd0);
        check128("midrst_state_out", state_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(VMix, EMix, w);
        drain();

        // Bytes-per-cycle sweep.
        sw_send(VInc, EInc);
        drain();
        sw_send(VMix, EMix);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
